// File: rtl/lifo_se_self_test.sv
// ============================================================================
// lifo_se_self_test : runs a fixed push/pop/replace script on an embedded LIFO
// and reports running / passed.                         Rev 1.0
// ============================================================================
`default_nettype none

module lifo_se_self_test #(
    parameter int DATA_SZ      = 16,
    parameter int DEPTH        = 8,
    parameter int FAULT_INJECT = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_running,
    output logic o_passed
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]      c_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0]      c_LAST  = CW'(DEPTH - 1);
    localparam logic [DATA_SZ-1:0] c_FLIP  = (FAULT_INJECT != 0) ? DATA_SZ'(1) : '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_LAST = 3'd2,
        S_PASS = 3'd3,
        S_FAIL = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [DATA_SZ-1:0] r_stk [DEPTH];
    logic [CW-1:0]      r_cnt;
    logic [3:0]         r_step, w_step_nxt;
    logic [CW-1:0]      r_idx, w_idx_nxt, w_rem;
    logic               w_push, w_pop, w_do_push, w_do_pop, w_last;
    logic [DATA_SZ-1:0] w_data, w_exp_s0, w_exp_s1, r_exp_s0, r_exp_s1;
    logic               w_exp_empty, w_exp_full, r_exp_empty, r_exp_full;
    logic               r_chk_vld, w_mismatch, w_empty, w_full;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == c_DEPTH);
    assign w_do_push = w_push && (r_state == S_RUN);
    assign w_do_pop  = w_pop  && (r_state == S_RUN);

    // Entries above the count are always zero, so s1 reads 0 with fewer than two entries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
            r_cnt <= '0;
        end else if (w_do_push && w_do_pop) begin
            r_stk[0] <= w_data;
            if (w_empty) r_cnt <= CW'(1);
        end else if (w_do_push && !w_full) begin
            r_stk[0] <= w_data;
            for (int i = 1; i < DEPTH; i++) r_stk[i] <= r_stk[i-1];
            r_cnt <= r_cnt + 1'b1;
        end else if (w_do_pop && !w_empty) begin
            for (int i = 0; i < DEPTH - 1; i++) r_stk[i] <= r_stk[i+1];
            r_stk[DEPTH-1] <= '0;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Script ROM: op for the current step plus the state expected one cycle later.
    always_comb begin
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_data      = '0;
        w_exp_s0    = '0;
        w_exp_s1    = '0;
        w_exp_empty = 1'b0;
        w_exp_full  = 1'b0;
        w_last      = 1'b0;
        w_rem       = '0;
        w_step_nxt  = r_step + 4'd1;
        w_idx_nxt   = r_idx;
        case (r_step)
            4'd0: begin
                w_push = 1'b1; w_data = DATA_SZ'(16'h1234);
                w_exp_s0 = DATA_SZ'(16'h1234) ^ c_FLIP;
            end
            4'd1: begin
                w_push = 1'b1; w_data = DATA_SZ'(16'h5678);
                w_exp_s0 = DATA_SZ'(16'h5678); w_exp_s1 = DATA_SZ'(16'h1234);
            end
            4'd2: begin
                w_push = 1'b1; w_pop = 1'b1; w_data = DATA_SZ'(16'h9ABC);
                w_exp_s0 = DATA_SZ'(16'h9ABC); w_exp_s1 = DATA_SZ'(16'h1234);
            end
            4'd3: begin
                w_pop = 1'b1; w_exp_s0 = DATA_SZ'(16'h1234);
            end
            4'd4, 4'd5: begin
                w_pop = 1'b1; w_exp_empty = 1'b1;
            end
            4'd6: begin
                w_push     = 1'b1;
                w_data     = DATA_SZ'(r_idx) + DATA_SZ'(1);
                w_exp_s0   = w_data;
                w_exp_s1   = DATA_SZ'(r_idx);
                w_exp_full = (r_idx == c_LAST);
                w_idx_nxt  = (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
                w_step_nxt = (r_idx == c_LAST) ? 4'd7 : 4'd6;
            end
            4'd7: begin
                w_push = 1'b1; w_data = DATA_SZ'(DEPTH + 1);
                w_exp_s0 = DATA_SZ'(DEPTH); w_exp_s1 = DATA_SZ'(DEPTH - 1);
                w_exp_full = 1'b1;
            end
            4'd8: begin
                w_pop       = 1'b1;
                w_rem       = c_LAST - r_idx;
                w_exp_s0    = DATA_SZ'(w_rem);
                w_exp_s1    = (w_rem == '0) ? '0 : DATA_SZ'(w_rem - 1'b1);
                w_exp_empty = (w_rem == '0);
                w_last      = (r_idx == c_LAST);
                w_idx_nxt   = r_idx + 1'b1;
                w_step_nxt  = 4'd8;
            end
            default: w_step_nxt = r_step;
        endcase
    end

    assign w_mismatch = r_chk_vld && ((r_stk[0] != r_exp_s0) || (r_stk[1] != r_exp_s1) ||
                                      (w_empty != r_exp_empty) || (w_full != r_exp_full));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_run) w_state_nxt = S_RUN;
            S_RUN:   if (w_mismatch) w_state_nxt = S_FAIL;
                     else if (w_last) w_state_nxt = S_LAST;
            S_LAST:  w_state_nxt = w_mismatch ? S_FAIL : S_PASS;
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_idx       <= '0;
            r_chk_vld   <= 1'b0;
            r_exp_s0    <= '0;
            r_exp_s1    <= '0;
            r_exp_empty <= 1'b0;
            r_exp_full  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_chk_vld <= (r_state == S_RUN);
            if (r_state == S_RUN) begin
                r_step      <= w_step_nxt;
                r_idx       <= w_idx_nxt;
                r_exp_s0    <= w_exp_s0;
                r_exp_s1    <= w_exp_s1;
                r_exp_empty <= w_exp_empty;
                r_exp_full  <= w_exp_full;
            end
        end
    end

    assign o_running = (r_state == S_RUN) || (r_state == S_LAST);
    assign o_passed  = (r_state == S_PASS);

endmodule

`default_nettype wire

// File: tb/tb_lifo_se_self_test.sv
// ============================================================================
// tb_lifo_se_self_test : directed bench for the default, fault-injected and
// DEPTH=4 self-test instances.                          Rev 1.0
// ============================================================================
`default_nettype none

module tb_lifo_se_self_test;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic run_m, pass_m, run_f, pass_f, run_4, pass_4;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lifo_se_self_test #(.DATA_SZ(16), .DEPTH(8), .FAULT_INJECT(0)) u_main (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .o_running(run_m), .o_passed(pass_m));
    lifo_se_self_test #(.DATA_SZ(16), .DEPTH(8), .FAULT_INJECT(1)) u_fault (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .o_running(run_f), .o_passed(pass_f));
    lifo_se_self_test #(.DATA_SZ(16), .DEPTH(4), .FAULT_INJECT(0)) u_d4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .o_running(run_4), .o_passed(pass_4));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_run_m"},  int'(run_m),  0);
        chk({tag, "_pass_m"}, int'(pass_m), 0);
        chk({tag, "_run_f"},  int'(run_f),  0);
        chk({tag, "_run_4"},  int'(run_4),  0);
    endtask

    // Start the script (held or single-cycle i_run), then watch to cycle 100.
    task automatic start_and_watch(input string tag, input bit pulse);
        int  done_m, done_f, done_4;
        bit  unstable;
        run = 1'b1;
        tick(1);
        chk({tag, "_start_run_m"}, int'(run_m), 1);
        chk({tag, "_start_run_f"}, int'(run_f), 1);
        chk({tag, "_start_run_4"}, int'(run_4), 1);
        if (pulse) run = 1'b0;
        done_m = 0; done_f = 0; done_4 = 0; unstable = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            tick(1);
            if (done_m != 0 && (run_m !== 1'b0 || pass_m !== 1'b1)) unstable = 1'b1;
            if (done_m == 0 && run_m === 1'b0) done_m = n;
            if (done_f == 0 && run_f === 1'b0) done_f = n;
            if (done_4 == 0 && run_4 === 1'b0) done_4 = n;
            if (pass_f !== 1'b0) unstable = 1'b1;
        end
        run = 1'b0;
        chk({tag, "_main_done_in_48"}, int'(done_m >= 1 && done_m <= 48), 1);
        chk({tag, "_main_passed"},     int'(pass_m), 1);
        chk({tag, "_main_running"},    int'(run_m),  0);
        chk({tag, "_stable"},          int'(unstable), 0);
        chk({tag, "_fault_done_by_3"}, int'(done_f >= 1 && done_f <= 3), 1);
        chk({tag, "_fault_passed"},    int'(pass_f), 0);
        chk({tag, "_d4_done_in_32"},   int'(done_4 >= 1 && done_4 <= 32), 1);
        chk({tag, "_d4_passed"},       int'(pass_4), 1);
    endtask

    initial begin
        // Reset held with i_run low: outputs stay 0.
        rst_n = 1'b0;
        run   = 1'b0;
        tick(1);
        all_zero("rst");
        tick(10);
        all_zero("rst_hold");

        // Held i_run after release.
        rst_n = 1'b1;
        tick(3);
        all_zero("idle");
        start_and_watch("held", 1'b0);

        // Single-cycle i_run pulse.
        rst_n = 1'b0;
        tick(2);
        all_zero("rst2");
        rst_n = 1'b1;
        tick(3);
        start_and_watch("pulse", 1'b1);

        // Asynchronous reset mid-run, then rerun.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(9);
        chk("mid_running", int'(run_m), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_run_m",  int'(run_m),  0);
        chk("async_pass_m", int'(pass_m), 0);
        chk("async_run_4",  int'(run_4),  0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        start_and_watch("rerun", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
